// File: rtl/psx_vram_pkg.sv
// Shared VRAM types and helpers for the GPU-side VRAM blocks.
// Addresses are {row[8:0], column[9:0]} into the 1024x512 16-bit VRAM.
package psx_vram_pkg;

  typedef logic [18:0] vram_addr_t;
  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } rb_state_t;

  function automatic vram_addr_t vram_addr(input logic [9:0] x, input logic [8:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vram_rb_fifo.sv
// First-word-fall-through FIFO for the readback pixel stream (pixel + last flag).
// Head entry is visible on dout while count is non-zero; dout reads zero when empty.
module vram_rb_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count < CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/vram_readback.sv
// GPU-side VRAM rectangle reader: issues one read per pixel in raster order and
// streams the returned pixels out on a valid/ready interface with a last marker.
module vram_readback
  import psx_vram_pkg::*;
#(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_33MHz,
  input  logic        rst,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  output logic        busy,
  output logic        done,
  output logic        GPU_re,
  output logic [18:0] GPU_addr,
  input  logic [15:0] GPU_data_out,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rb_state_t state, state_nx;

  logic [9:0]        x0_q, w_q, h_q;
  logic [9:0]        cx, col, row;
  logic [8:0]        cy;
  logic              re_last;
  logic [RD_LAT-1:0] tag_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [16:0]       fifo_head;
  logic              credit_ok;
  logic              final_rd;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_y0_msb;

  assign unused_y0_msb = y0[9];

  // Every issued read reserves a FIFO slot, so a returning pixel always has room.
  always_comb begin
    credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
    final_rd  = (row == h_q - 10'd1) && (col == w_q - 10'd1);
    push      = tag_pipe[RD_LAT-1];
    pop       = pix_valid && pix_ready;
  end

  always_ff @(posedge clk_33MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = ((w == '0) || (h == '0)) ? FIN : ISSUE;
      end
      ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (final_rd) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && pix_last) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == FIN);

  always_ff @(posedge clk_33MHz or posedge rst) begin
    if (rst) begin
      x0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      cx        <= '0;
      cy        <= '0;
      col       <= '0;
      row       <= '0;
      GPU_re    <= 1'b0;
      GPU_addr  <= '0;
      re_last   <= 1'b0;
      tag_pipe  <= '0;
      last_pipe <= '0;
      inflight  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        x0_q <= x0;
        w_q  <= w;
        h_q  <= h;
        cx   <= x0;
        cy   <= y0[8:0];
        col  <= '0;
        row  <= '0;
      end else if (issue) begin
        if (col == w_q - 10'd1) begin
          col <= '0;
          cx  <= x0_q;
          row <= row + 10'd1;
          cy  <= cy + 9'd1;
        end else begin
          col <= col + 10'd1;
          cx  <= cx + 10'd1;
        end
      end

      GPU_re  <= issue;
      re_last <= issue && final_rd;
      if (issue) GPU_addr <= vram_addr(cx, cy);

      // Tags follow the registered strobe so they line up with the VRAM's own pipe.
      tag_pipe[0]  <= GPU_re;
      last_pipe[0] <= GPU_re && re_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_pipe[i]  <= tag_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end

      case ({issue, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  vram_rb_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_33MHz),
    .rst   (rst),
    .push  (push),
    .din   ({last_pipe[RD_LAT-1], GPU_data_out}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign pix_valid = (fifo_count != '0);
  assign pix_data  = fifo_head[15:0];
  assign pix_last  = fifo_head[16];

endmodule

// File: tb/tb_vram_readback.sv
// Directed bench for vram_readback with a fixed-latency VRAM model returning addr[15:0].
module tb_vram_readback;

  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned FIFO_DEPTH = 8;

  logic        clk_33MHz;
  logic        rst;
  logic        start;
  logic [9:0]  x0, y0, w, h;
  logic        busy, done;
  logic        GPU_re;
  logic [18:0] GPU_addr;
  logic [15:0] GPU_data_out;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_pop_cyc = 0;
  int start_cyc = 0;
  bit valid_seen = 0;
  logic [18:0] addr_q[$];
  logic [16:0] pix_q[$];

  vram_readback #(
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_33MHz    (clk_33MHz),
    .rst          (rst),
    .start        (start),
    .x0           (x0),
    .y0           (y0),
    .w            (w),
    .h            (h),
    .busy         (busy),
    .done         (done),
    .GPU_re       (GPU_re),
    .GPU_addr     (GPU_addr),
    .GPU_data_out (GPU_data_out),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_last     (pix_last)
  );

  initial clk_33MHz = 1'b0;
  always #15 clk_33MHz = ~clk_33MHz;

  always @(posedge clk_33MHz) cyc <= cyc + 1;

  // VRAM model: fixed read latency, data = address low bits.
  logic        re_p   [RD_LAT];
  logic [18:0] addr_p [RD_LAT];
  always @(posedge clk_33MHz) begin
    re_p[0]   <= GPU_re;
    addr_p[0] <= GPU_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      re_p[i]   <= re_p[i-1];
      addr_p[i] <= addr_p[i-1];
    end
  end
  assign GPU_data_out = (re_p[RD_LAT-1] === 1'b1) ? addr_p[RD_LAT-1][15:0] : 16'hBAD0;

  always @(negedge clk_33MHz) begin
    if (!rst) begin
      if (GPU_re) addr_q.push_back(GPU_addr);
      if (pix_valid) valid_seen = 1;
      if (pix_valid && pix_ready) begin
        pix_q.push_back({pix_last, pix_data});
        if (pix_last) last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic [18:0] exp_addr(input int jx, input int jy, input int jw, input int i);
    logic [9:0] xx;
    logic [8:0] yy;
    xx = 10'((jx + (i % jw)) % 1024);
    yy = 9'((jy + (i / jw)) % 512);
    return {yy, xx};
  endfunction

  task automatic clear_mon();
    addr_q.delete();
    pix_q.delete();
    valid_seen = 0;
  endtask

  task automatic start_job(input int jx, input int jy, input int jw, input int jh);
    @(posedge clk_33MHz);
    #1;
    x0 = 10'(jx); y0 = 10'(jy); w = 10'(jw); h = 10'(jh);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk_33MHz);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int limit);
    int i;
    i = 0;
    while (done_cnt == d0 && i < limit) begin
      @(posedge clk_33MHz);
      i++;
    end
    repeat (3) @(negedge clk_33MHz);
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic check_job(input string name, input int jx, input int jy, input int jw,
                           input int jh, input int d0);
    int n, bad, first;
    logic [18:0] ea;
    logic [16:0] ep;
    n = jw * jh;
    checks++;
    if (addr_q.size() != n) begin
      errors++;
      $display("FAIL %s_reads: got %0d reads, expected %0d", name, addr_q.size(), n);
    end
    bad = 0; first = -1;
    for (int i = 0; i < n && i < addr_q.size(); i++) begin
      ea = exp_addr(jx, jy, jw, i);
      if (addr_q[i] !== ea) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_addr: %0d wrong, first at %0d got %h expected %h", name, bad, first,
               addr_q[first], exp_addr(jx, jy, jw, first));
    end
    checks++;
    if (pix_q.size() != n) begin
      errors++;
      $display("FAIL %s_pixels: got %0d pixels, expected %0d", name, pix_q.size(), n);
    end
    bad = 0; first = -1;
    for (int i = 0; i < n && i < pix_q.size(); i++) begin
      ea = exp_addr(jx, jy, jw, i);
      ep = {(i == n - 1), ea[15:0]};
      if (pix_q[i] !== ep) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      ea = exp_addr(jx, jy, jw, first);
      errors++;
      $display("FAIL %s_stream: %0d wrong, first at %0d got {last,data}=%h expected %h", name,
               bad, first, pix_q[first], {(first == n - 1), ea[15:0]});
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d pulses, expected 1", name, done_cnt - d0);
    end
    if (n > 0) begin
      checks++;
      if (done_cyc - last_pop_cyc != 1) begin
        errors++;
        $display("FAIL %s_done_timing: done %0d cycles after last handshake, expected 1", name,
                 done_cyc - last_pop_cyc);
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({busy, done, GPU_re, pix_valid, pix_last} !== 5'b0) begin
      errors++;
      $display("FAIL %s_flags: busy/done/re/valid/last got %b expected 00000", name,
               {busy, done, GPU_re, pix_valid, pix_last});
    end
    checks++;
    if (GPU_addr !== 19'h0) begin
      errors++;
      $display("FAIL %s_addr: got %h expected 00000", name, GPU_addr);
    end
    checks++;
    if (pix_data !== 16'h0) begin
      errors++;
      $display("FAIL %s_pix_data: got %h expected 0000", name, pix_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
    x0 = '0; y0 = '0; w = '0; h = '0;
    repeat (3) @(posedge clk_33MHz);
    @(negedge clk_33MHz);
    check_idle_outputs("reset");
    #1 rst = 1'b0;
    repeat (2) @(posedge clk_33MHz);
  endtask

  task automatic test_basic();
    int d0;
    clear_mon();
    pix_ready = 1'b1;
    d0 = done_cnt;
    start_job(3, 3, 4, 2);
    wait_done("basic", d0, 200);
    checks++;
    if (addr_q.size() < 8 || addr_q[0] !== 19'h00C03 || addr_q[7] !== 19'h01006) begin
      errors++;
      $display("FAIL basic_corners: got %0d reads, first/last expected 00c03/01006", addr_q.size());
    end
    check_job("basic", 3, 3, 4, 2, d0);
  endtask

  task automatic test_backpressure();
    int d0;
    logic [18:0] ea;
    clear_mon();
    pix_ready = 1'b0;
    d0 = done_cnt;
    start_job(20, 40, 16, 1);
    repeat (19) @(posedge clk_33MHz);
    @(negedge clk_33MHz);
    checks++;
    if (addr_q.size() != FIFO_DEPTH) begin
      errors++;
      $display("FAIL bp_stall: got %0d reads while stalled, expected %0d", addr_q.size(), FIFO_DEPTH);
    end
    ea = exp_addr(20, 40, 16, 0);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== ea[15:0]) begin
      errors++;
      $display("FAIL bp_head: valid=%b data=%h expected valid=1 data=%h", pix_valid, pix_data, ea[15:0]);
    end
    @(posedge clk_33MHz);
    #1 pix_ready = 1'b1;
    wait_done("bp", d0, 300);
    check_job("bp", 20, 40, 16, 1, d0);
  endtask

  task automatic test_empty();
    int d0;
    clear_mon();
    pix_ready = 1'b1;
    d0 = done_cnt;
    start_job(5, 5, 0, 5);
    repeat (8) @(posedge clk_33MHz);
    @(negedge clk_33MHz);
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL empty_reads: got %0d reads expected 0", addr_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1 || done_cyc - start_cyc != 1) begin
      errors++;
      $display("FAIL empty_done: pulses=%0d delay=%0d expected 1 and 1", done_cnt - d0,
               done_cyc - start_cyc);
    end
    checks++;
    if (valid_seen) begin
      errors++;
      $display("FAIL empty_valid: got pix_valid=1 expected never");
    end
  endtask

  task automatic test_wrap();
    int d0;
    clear_mon();
    pix_ready = 1'b1;
    d0 = done_cnt;
    start_job(1022, 511, 4, 2);
    wait_done("wrap", d0, 200);
    checks++;
    if (addr_q.size() < 5 || addr_q[0] !== 19'h7FFFE || addr_q[2] !== 19'h7FC00 ||
        addr_q[4] !== 19'h003FE) begin
      errors++;
      $display("FAIL wrap_corners: got %0d reads, [0]/[2]/[4] expected 7fffe/7fc00/003fe",
               addr_q.size());
    end
    check_job("wrap", 1022, 511, 4, 2, d0);
  endtask

  task automatic test_start_while_busy();
    int d0;
    clear_mon();
    pix_ready = 1'b1;
    d0 = done_cnt;
    start_job(0, 7, 640, 1);
    repeat (50) @(posedge clk_33MHz);
    start_job(100, 200, 5, 1);
    wait_done("busy_start", d0, 2000);
    check_job("busy_start", 0, 7, 640, 1, d0);
  endtask

  task automatic test_reset_mid_run();
    int d0, i;
    clear_mon();
    pix_ready = 1'b1;
    start_job(0, 7, 640, 1);
    i = 0;
    while (pix_q.size() < 100 && i < 1000) begin
      @(negedge clk_33MHz);
      i++;
    end
    checks++;
    if (pix_q.size() < 100) begin
      errors++;
      $display("FAIL midrst_progress: got %0d pixels expected 100", pix_q.size());
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    repeat (3) @(posedge clk_33MHz);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk_33MHz);
    clear_mon();
    d0 = done_cnt;
    start_job(10, 20, 5, 3);
    wait_done("after_rst", d0, 300);
    check_job("after_rst", 10, 20, 5, 3, d0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(30 * 50000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
